sw_alloc: RTL

Switch allocator for the 5x5 router. It sits between the per-input routing computation (rtcomp) and the crossbar. Each input port requests the output port computed for its head flit. For every output port, the block arbitrates round-robin among the requesting inputs and locks the winning input to that output from the head flit until its tail flit has transferred. It drives the crossbar select and write-enable signals and the per-input transfer strobes.

---
 rtl/sw_alloc_if.sv | 36 +++
 rtl/sw_alloc.sv | 127 ++++++++++++
 2 files changed

// File: rtl/sw_alloc_if.sv
// sw_alloc_if: bundle between the per-input routing stage / output credit
// logic and the switch allocator.
//   req      : input i has a head flit waiting for an output
//   req_port : requested output of input i, bits [i*PORTW +: PORTW]
//   in_vld   : input i has a flit at its head
//   in_tail  : flit at the head of input i is a tail flit
//   out_rdy  : output o can accept a flit (credit available)
//   gnt      : input i owns an output
//   out_sel  : owning input of output o, bits [o*PORTW +: PORTW]
//   out_vld  : crossbar write enable for output o
//   xfer     : dequeue strobe for input i
// master = upstream side (drives requests/credits), slave = allocator.
interface sw_alloc_if #(
    parameter int NPORT = 5,
    parameter int PORTW = 3
);
    logic [NPORT-1:0]       req;
    logic [NPORT*PORTW-1:0] req_port;
    logic [NPORT-1:0]       in_vld;
    logic [NPORT-1:0]       in_tail;
    logic [NPORT-1:0]       out_rdy;
    logic [NPORT-1:0]       gnt;
    logic [NPORT*PORTW-1:0] out_sel;
    logic [NPORT-1:0]       out_vld;
    logic [NPORT-1:0]       xfer;

    modport master (
        output req, req_port, in_vld, in_tail, out_rdy,
        input  gnt, out_sel, out_vld, xfer
    );

    modport slave (
        input  req, req_port, in_vld, in_tail, out_rdy,
        output gnt, out_sel, out_vld, xfer
    );
endinterface

// File: rtl/sw_alloc.sv
// sw_alloc: switch allocator for the 5x5 router.
// Per output port a round-robin arbiter picks one requesting input and locks
// it to that output from head flit until its tail flit has transferred.
// Ports:
//   clk  : clock, rising edge
//   rst_ : asynchronous, active-high reset
//   bus  : sw_alloc_if slave (requests, credits, grants, crossbar controls)
module sw_alloc #(
    parameter int NPORT = 5,
    parameter int PORTW = 3
) (
    input  logic     clk,
    input  logic     rst_,
    sw_alloc_if.slave bus
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e           state_q [NPORT];
    state_e           state_d [NPORT];
    logic [PORTW-1:0] owner_q [NPORT];
    logic [PORTW-1:0] owner_d [NPORT];
    logic [PORTW-1:0] rr_q    [NPORT];
    logic [PORTW-1:0] rr_d    [NPORT];

    logic [NPORT-1:0]       owned;
    logic [NPORT-1:0]       cand [NPORT];
    logic [NPORT-1:0]       gnt_w;
    logic [NPORT*PORTW-1:0] out_sel_w;
    logic [NPORT-1:0]       out_vld_w;
    logic [NPORT-1:0]       xfer_w;

    // Inputs already holding a lock on some output.
    always_comb begin
        owned = '0;
        for (int unsigned o = 0; o < NPORT; o++) begin
            if (state_q[o] == BUSY) begin
                owned[owner_q[o]] = 1'b1;
            end
        end
    end

    // Candidate matrix. Requests to ports >= NPORT never match any o.
    always_comb begin
        for (int unsigned o = 0; o < NPORT; o++) begin
            cand[o] = '0;
            for (int unsigned i = 0; i < NPORT; i++) begin
                cand[o][i] = bus.req[i]
                           && (bus.req_port[i*PORTW +: PORTW] == PORTW'(o))
                           && !owned[i];
            end
        end
    end

    // Crossbar controls decoded from registered lock state.
    always_comb begin
        gnt_w     = '0;
        out_sel_w = '0;
        out_vld_w = '0;
        xfer_w    = '0;
        for (int unsigned o = 0; o < NPORT; o++) begin
            if (state_q[o] == BUSY) begin
                gnt_w[owner_q[o]]              = 1'b1;
                out_sel_w[o*PORTW +: PORTW]    = owner_q[o];
                out_vld_w[o]                   = bus.in_vld[owner_q[o]] & bus.out_rdy[o];
                xfer_w[owner_q[o]]             = bus.in_vld[owner_q[o]] & bus.out_rdy[o];
            end
        end
    end

    // Next-state: a BUSY output only releases on its tail transfer; an IDLE
    // output grants the first candidate at or after rr_ptr. An input that
    // releases this cycle is still marked owned, so it cannot be regranted
    // until the following idle cycle.
    always_comb begin
        logic        found;
        int unsigned idx;
        found = 1'b0;
        idx   = 0;
        for (int unsigned o = 0; o < NPORT; o++) begin
            state_d[o] = state_q[o];
            owner_d[o] = owner_q[o];
            rr_d[o]    = rr_q[o];
            found      = 1'b0;
            if (state_q[o] == BUSY) begin
                if (out_vld_w[o] && bus.in_tail[owner_q[o]]) begin
                    state_d[o] = IDLE;
                end
            end else begin
                for (int unsigned k = 0; k < NPORT; k++) begin
                    idx = (32'(rr_q[o]) + k) % NPORT;
                    if (!found && cand[o][PORTW'(idx)]) begin
                        found      = 1'b1;
                        state_d[o] = BUSY;
                        owner_d[o] = PORTW'(idx);
                        rr_d[o]    = PORTW'((idx + 1) % NPORT);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst_) begin
        if (rst_) begin
            for (int unsigned o = 0; o < NPORT; o++) begin
                state_q[o] <= IDLE;
                owner_q[o] <= '0;
                rr_q[o]    <= '0;
            end
        end else begin
            for (int unsigned o = 0; o < NPORT; o++) begin
                state_q[o] <= state_d[o];
                owner_q[o] <= owner_d[o];
                rr_q[o]    <= rr_d[o];
            end
        end
    end

    assign bus.gnt     = gnt_w;
    assign bus.out_sel = out_sel_w;
    assign bus.out_vld = out_vld_w;
    assign bus.xfer    = xfer_w;

endmodule
